// File: rtl/regfile_pkg.sv
// Shared constants, the data word type and the I/O address helper for the MMIO register file.
package regfile_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 5;
    // Four channels at stride 2 from 20 would place channel 3 on the counter at 26, so three fit.
    localparam int NUM_IO_DEF    = 3;
    localparam int IO_BASE_DEF   = 20;
    localparam int IO_STRIDE_DEF = 2;
    localparam int CNT_REG_DEF   = 26;
    localparam int BYPASS_DEF    = 1;

    typedef logic [DATA_W_DEF-1:0] word_t;

    function automatic int io_addr(input int k, input int base, input int stride);
        return base + k * stride;
    endfunction

endpackage

// File: rtl/regfile_io_slot.sv
// One memory-mapped input channel: stored value plus pending/overrun status.
module regfile_io_slot #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_io_valid,
    input  logic [DATA_W-1:0] i_io_data,
    input  logic              i_cpu_we,
    input  logic [DATA_W-1:0] i_cpu_data,
    input  logic              i_rd_clr,
    output logic [DATA_W-1:0] o_q,
    output logic              o_pending,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_q;
    logic              r_pending;
    logic              r_overrun;

    // Peripheral data beats the CPU; a set of either flag beats its clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q       <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_io_valid)
                r_q <= i_io_data;
            else if (i_cpu_we)
                r_q <= i_cpu_data;

            if (i_io_valid)
                r_pending <= 1'b1;
            else if (i_rd_clr)
                r_pending <= 1'b0;

            if (i_io_valid && r_pending && !i_rd_clr)
                r_overrun <= 1'b1;
            else if (i_cpu_we)
                r_overrun <= 1'b0;
        end
    end

    assign o_q       = r_q;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/regfile_mmio.sv
// 2-read/1-write register file with memory-mapped input channels, a cycle counter and optional bypass.
module regfile_mmio
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_IO    = NUM_IO_DEF,
    parameter int IO_BASE   = IO_BASE_DEF,
    parameter int IO_STRIDE = IO_STRIDE_DEF,
    parameter int CNT_REG   = CNT_REG_DEF,
    parameter int BYPASS    = BYPASS_DEF
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     ctrl_writeEnable,
    input  logic [ADDR_W-1:0]        ctrl_writeReg,
    input  logic [DATA_W-1:0]        data_writeReg,
    input  logic [ADDR_W-1:0]        ctrl_readRegA,
    input  logic [ADDR_W-1:0]        ctrl_readRegB,
    input  logic                     ctrl_readValid,
    output logic [DATA_W-1:0]        data_readRegA,
    output logic [DATA_W-1:0]        data_readRegB,
    input  logic [NUM_IO-1:0]        io_valid,
    input  logic [NUM_IO*DATA_W-1:0] io_data,
    output logic [NUM_IO*DATA_W-1:0] io_q,
    output logic [NUM_IO-1:0]        io_pending,
    output logic [NUM_IO-1:0]        io_overrun,
    input  logic                     cnt_en
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LP_CNT = ADDR_W'(CNT_REG);

    if (CNT_REG <= 0 || CNT_REG >= DEPTH) begin : g_bad_cnt
        $error("regfile_mmio: CNT_REG out of range");
    end
    if (IO_STRIDE == 0) begin : g_bad_stride
        $error("regfile_mmio: IO_STRIDE must be nonzero");
    end

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] r_cnt;
    logic [DATA_W-1:0] w_io_q [NUM_IO];
    logic [NUM_IO-1:0] w_io_hit;
    logic [NUM_IO-1:0] w_sel_a;
    logic [NUM_IO-1:0] w_sel_b;
    logic              w_wr_nz;
    logic              w_commit;
    logic              w_ord_we;
    logic [DATA_W-1:0] w_stored_a;
    logic [DATA_W-1:0] w_stored_b;

    assign w_wr_nz = ctrl_writeEnable && (ctrl_writeReg != '0);

    for (genvar k = 0; k < NUM_IO; k++) begin : g_io
        localparam int                A_INT = io_addr(k, IO_BASE, IO_STRIDE);
        localparam logic [ADDR_W-1:0] A_K   = ADDR_W'(A_INT);

        if (A_INT <= 0 || A_INT >= DEPTH || A_INT == CNT_REG) begin : g_bad_io
            $error("regfile_mmio: I/O address out of range or on the counter");
        end

        assign w_io_hit[k] = w_wr_nz && (ctrl_writeReg == A_K);
        assign w_sel_a[k]  = (ctrl_readRegA == A_K);
        assign w_sel_b[k]  = (ctrl_readRegB == A_K);

        regfile_io_slot #(.DATA_W(DATA_W)) u_slot (
            .i_clk      (clock),
            .i_rst_n    (ctrl_reset),
            .i_io_valid (io_valid[k]),
            .i_io_data  (io_data[k*DATA_W +: DATA_W]),
            .i_cpu_we   (w_io_hit[k]),
            .i_cpu_data (data_writeReg),
            .i_rd_clr   (ctrl_readValid && (w_sel_a[k] || w_sel_b[k])),
            .o_q        (w_io_q[k]),
            .o_pending  (io_pending[k]),
            .o_overrun  (io_overrun[k])
        );

        assign io_q[k*DATA_W +: DATA_W] = w_io_q[k];
    end

    // A CPU write overridden by its channel's io_valid neither commits nor bypasses.
    assign w_commit = w_wr_nz && !(|(w_io_hit & io_valid));
    assign w_ord_we = w_commit && (ctrl_writeReg != LP_CNT) && !(|w_io_hit);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_ord_we) begin
            r_regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset)
            r_cnt <= '0;
        else if (w_commit && ctrl_writeReg == LP_CNT)
            r_cnt <= data_writeReg;
        else if (cnt_en)
            r_cnt <= r_cnt + DATA_W'(1);
    end

    always_comb begin
        w_stored_a = r_regs[ctrl_readRegA];
        if (ctrl_readRegA == LP_CNT) w_stored_a = r_cnt;
        for (int k = 0; k < NUM_IO; k++)
            if (w_sel_a[k]) w_stored_a = w_io_q[k];
        if (ctrl_readRegA == '0) w_stored_a = '0;
    end

    always_comb begin
        w_stored_b = r_regs[ctrl_readRegB];
        if (ctrl_readRegB == LP_CNT) w_stored_b = r_cnt;
        for (int k = 0; k < NUM_IO; k++)
            if (w_sel_b[k]) w_stored_b = w_io_q[k];
        if (ctrl_readRegB == '0) w_stored_b = '0;
    end

    assign data_readRegA = ((BYPASS != 0) && w_commit && (ctrl_writeReg == ctrl_readRegA))
                           ? data_writeReg : w_stored_a;
    assign data_readRegB = ((BYPASS != 0) && w_commit && (ctrl_writeReg == ctrl_readRegB))
                           ? data_writeReg : w_stored_b;

endmodule

// File: tb/tb_regfile_mmio.sv
// Bench for regfile_mmio: vector table, directed corner sequences and a randomized scoreboard run.
module tb_regfile_mmio;

    localparam int NIO = 3;
    localparam int CNT = 26;

    logic              clock;
    logic              ctrl_reset;
    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [31:0]       data_writeReg;
    logic [4:0]        ctrl_readRegA;
    logic [4:0]        ctrl_readRegB;
    logic              ctrl_readValid;
    logic [31:0]       data_readRegA;
    logic [31:0]       data_readRegB;
    logic [NIO-1:0]    io_valid;
    logic [NIO*32-1:0] io_data;
    logic [NIO*32-1:0] io_q;
    logic [NIO-1:0]    io_pending;
    logic [NIO-1:0]    io_overrun;
    logic              cnt_en;

    logic [31:0]       nb_A;
    logic [31:0]       nb_B;
    logic [NIO*32-1:0] nb_q;
    logic [NIO-1:0]    nb_pend;
    logic [NIO-1:0]    nb_ovr;

    regfile_mmio #(.NUM_IO(NIO), .CNT_REG(CNT), .BYPASS(1)) u_dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .ctrl_readValid(ctrl_readValid), .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB), .io_valid(io_valid), .io_data(io_data),
        .io_q(io_q), .io_pending(io_pending), .io_overrun(io_overrun), .cnt_en(cnt_en)
    );

    regfile_mmio #(.NUM_IO(NIO), .CNT_REG(CNT), .BYPASS(0)) u_nb (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .ctrl_readValid(ctrl_readValid), .data_readRegA(nb_A),
        .data_readRegB(nb_B), .io_valid(io_valid), .io_data(io_data),
        .io_q(nb_q), .io_pending(nb_pend), .io_overrun(nb_ovr), .cnt_en(cnt_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: what each address holds, plus the per-channel flags.
    logic [31:0]    m_mem [32];
    logic [NIO-1:0] m_pend;
    logic [NIO-1:0] m_ovr;

    function automatic logic [4:0] ioa(input int k);
        return 5'(20 + 2 * k);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_pend = '0;
        m_ovr  = '0;
    endtask

    function automatic logic m_commit();
        logic c;
        c = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        for (int k = 0; k < NIO; k++)
            if (ctrl_writeReg == ioa(k) && io_valid[k]) c = 1'b0;
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (m_commit() && ctrl_writeReg == a) return data_writeReg;
        return m_mem[a];
    endfunction

    task automatic model_update();
        logic           c;
        logic           clr;
        logic           cpuw;
        logic [31:0]    cnt_next;
        logic [NIO-1:0] np;
        logic [NIO-1:0] no;
        c = m_commit();
        for (int k = 0; k < NIO; k++) begin
            clr   = ctrl_readValid && (ctrl_readRegA == ioa(k) || ctrl_readRegB == ioa(k));
            cpuw  = ctrl_writeEnable && (ctrl_writeReg == ioa(k));
            no[k] = (io_valid[k] && m_pend[k] && !clr) ? 1'b1 : (cpuw ? 1'b0 : m_ovr[k]);
            np[k] = io_valid[k] ? 1'b1 : (clr ? 1'b0 : m_pend[k]);
        end
        if (c && ctrl_writeReg == 5'(CNT)) cnt_next = data_writeReg;
        else if (cnt_en)                   cnt_next = m_mem[CNT] + 32'd1;
        else                               cnt_next = m_mem[CNT];
        for (int k = 0; k < NIO; k++)
            if (io_valid[k]) m_mem[ioa(k)] = io_data[k*32 +: 32];
        if (c) m_mem[ctrl_writeReg] = data_writeReg;
        m_mem[CNT] = cnt_next;
        m_pend = np;
        m_ovr  = no;
    endtask

    task automatic model_check();
        chk("rand_rdA", data_readRegA, exp_rd(ctrl_readRegA));
        chk("rand_rdB", data_readRegB, exp_rd(ctrl_readRegB));
        chk("rand_nbA", nb_A, m_mem[ctrl_readRegA]);
        chk("rand_nbB", nb_B, m_mem[ctrl_readRegB]);
        chk("rand_pend", 32'(io_pending), 32'(m_pend));
        chk("rand_ovr", 32'(io_overrun), 32'(m_ovr));
        for (int k = 0; k < NIO; k++) chk("rand_ioq", io_q[k*32 +: 32], m_mem[ioa(k)]);
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0; ctrl_readValid = 1'b0;
        io_valid = '0; io_data = '0; cnt_en = 1'b0;
    endtask

    task automatic fin();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = a; data_writeReg = d;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rv;
        logic [2:0]  iov;
        logic [31:0] iod;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  ep;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{1'b1, 5'd5,  32'h1234, 5'd5,  5'd0,  1'b0, 3'b000, 32'h0,  32'h1234, 32'h0,    3'b000};
        vt[1] = '{1'b0, 5'd0,  32'h0,    5'd5,  5'd7,  1'b0, 3'b000, 32'h0,  32'h1234, 32'h0,    3'b000};
        vt[2] = '{1'b1, 5'd0,  32'hDEAD, 5'd0,  5'd5,  1'b0, 3'b000, 32'h0,  32'h0,    32'h1234, 3'b000};
        vt[3] = '{1'b1, 5'd7,  32'hBEEF, 5'd7,  5'd0,  1'b0, 3'b000, 32'h0,  32'hBEEF, 32'h0,    3'b000};
        vt[4] = '{1'b1, 5'd20, 32'h22,   5'd20, 5'd7,  1'b0, 3'b001, 32'h11, 32'h0,    32'hBEEF, 3'b000};
        vt[5] = '{1'b0, 5'd0,  32'h0,    5'd20, 5'd0,  1'b0, 3'b000, 32'h0,  32'h11,   32'h0,    3'b001};
        vt[6] = '{1'b0, 5'd0,  32'h0,    5'd20, 5'd0,  1'b1, 3'b000, 32'h0,  32'h11,   32'h0,    3'b001};
        vt[7] = '{1'b0, 5'd0,  32'h0,    5'd22, 5'd20, 1'b0, 3'b000, 32'h0,  32'h0,    32'h11,   3'b000};

        idle();
        ctrl_reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'(CNT);
        @(negedge clock);
        chk("rst_rdA", data_readRegA, 32'h0);
        chk("rst_cnt", data_readRegB, 32'h0);
        chk("rst_pend", 32'(io_pending), 32'h0);
        chk("rst_ioq", io_q[31:0], 32'h0);
        @(posedge clock);
        #1 ctrl_reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            idle();
            ctrl_writeEnable = vt[i].we; ctrl_writeReg = vt[i].wa; data_writeReg = vt[i].wd;
            ctrl_readRegA = vt[i].ra; ctrl_readRegB = vt[i].rb; ctrl_readValid = vt[i].rv;
            io_valid = vt[i].iov; io_data = {NIO{vt[i].iod}};
            @(negedge clock);
            chk($sformatf("vec%0d_A", i), data_readRegA, vt[i].ea);
            chk($sformatf("vec%0d_B", i), data_readRegB, vt[i].eb);
            chk($sformatf("vec%0d_pend", i), 32'(io_pending), 32'(vt[i].ep));
            fin();
        end

        // Channel 1 (address 22) status sequence.
        idle(); io_valid = 3'b010; io_data = {NIO{32'hA1}};
        @(negedge clock); fin();
        io_data = {NIO{32'hA2}};
        @(negedge clock); chk("po_pend_set", 32'(io_pending[1]), 32'h1); fin();
        idle(); ctrl_readRegB = 5'd22; ctrl_readValid = 1'b1;
        @(negedge clock); chk("po_ovr_set", 32'(io_overrun[1]), 32'h1);
        chk("po_rdB", data_readRegB, 32'hA2); fin();
        idle(); wr(5'd22, 32'h33);
        @(negedge clock); chk("po_pend_clr", 32'(io_pending[1]), 32'h0);
        chk("po_ovr_keep", 32'(io_overrun[1]), 32'h1); fin();
        idle(); io_valid = 3'b010; io_data = {NIO{32'hA5}}; ctrl_readRegB = 5'd22; ctrl_readValid = 1'b1;
        @(negedge clock); chk("po_ovr_cpuclr", 32'(io_overrun[1]), 32'h0);
        chk("po_cpu_q", io_q[63:32], 32'h33); fin();
        @(negedge clock); chk("po_pend_set2", 32'(io_pending[1]), 32'h1); fin();
        ctrl_readValid = 1'b0;
        @(negedge clock); chk("po_setwins", 32'(io_pending[1]), 32'h1);
        chk("po_noovr", 32'(io_overrun[1]), 32'h0); fin();
        wr(5'd22, 32'h44);
        @(negedge clock); chk("po_ovr_again", 32'(io_overrun[1]), 32'h1); fin();
        idle(); wr(5'd22, 32'h55);
        @(negedge clock); chk("po_ovr_setwins", 32'(io_overrun[1]), 32'h1);
        chk("po_io_beats_cpu", io_q[63:32], 32'hA5); fin();
        idle();
        @(negedge clock); chk("po_ovr_clr", 32'(io_overrun[1]), 32'h0); fin();

        // Counter wrap and write priority.
        idle(); wr(5'(CNT), 32'hFFFF_FFFE); cnt_en = 1'b1; ctrl_readRegA = 5'(CNT);
        @(negedge clock); chk("cnt_byp", data_readRegA, 32'hFFFF_FFFE); fin();
        ctrl_writeEnable = 1'b0;
        @(negedge clock); chk("cnt_wr_noinc", data_readRegA, 32'hFFFF_FFFE); fin();
        @(negedge clock); chk("cnt_max", data_readRegA, 32'hFFFF_FFFF); fin();
        @(negedge clock); chk("cnt_wrap", data_readRegA, 32'h0); fin();
        @(negedge clock); chk("cnt_one", data_readRegA, 32'h1); fin();

        // Bypass-disabled build shows the old value during the write.
        idle(); wr(5'd9, 32'h5555); ctrl_readRegA = 5'd9;
        @(negedge clock); chk("byp1_A", data_readRegA, 32'h5555);
        chk("byp0_A_old", nb_A, 32'h0); fin();
        ctrl_writeEnable = 1'b0;
        @(negedge clock); chk("byp0_A_new", nb_A, 32'h5555); fin();

        // Reset asserted mid-cycle clears immediately.
        idle(); wr(5'd5, 32'h1234); io_valid = 3'b011; io_data = {NIO{32'h99}}; cnt_en = 1'b1;
        @(negedge clock); fin();
        @(negedge clock); fin();
        idle(); ctrl_readRegA = 5'd5; ctrl_readRegB = 5'(CNT);
        #3 ctrl_reset = 1'b0;
        #1;
        chk("mrst_r5", data_readRegA, 32'h0);
        chk("mrst_cnt", data_readRegB, 32'h0);
        chk("mrst_pend", 32'(io_pending), 32'h0);
        chk("mrst_ovr", 32'(io_overrun), 32'h0);
        chk("mrst_ioq", io_q[31:0], 32'h0);
        model_reset();
        @(posedge clock);
        #1 ctrl_reset = 1'b1;
        wr(5'd5, 32'h77);
        @(negedge clock); fin();
        idle(); ctrl_readRegA = 5'd5;
        @(negedge clock); chk("mrst_after", data_readRegA, 32'h77); fin();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 10000; n++) begin
            ctrl_writeEnable = ($urandom_range(0, 1) == 1);
            ctrl_writeReg    = ($urandom_range(0, 1) == 1) ? ioa($urandom_range(0, NIO - 1))
                             : (($urandom_range(0, 3) == 0) ? 5'(CNT) : 5'($urandom_range(0, 31)));
            data_writeReg    = $urandom;
            ctrl_readRegA    = ($urandom_range(0, 1) == 1) ? ioa($urandom_range(0, NIO - 1))
                                                           : 5'($urandom_range(0, 31));
            ctrl_readRegB    = ($urandom_range(0, 2) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
            ctrl_readValid   = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < NIO; k++) io_valid[k] = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NIO; k++) io_data[k*32 +: 32] = $urandom;
            cnt_en           = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            model_check();
            fin();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
